multi_channel_iot_monitor: RTL and testbench

//  Parametrised successor to the single-channel active IoT device counter.
//  - Keeps N_CH independent up/down counters of active devices, one per channel.
//  - Adds selectable wrap or saturate arithmetic, per-channel clear and boundary event flags.
//  - Adds a registered total across all channels and per-channel threshold alarms.
//  - Sits between the device-event front end and the status/alarm reporting logic.

---
 rtl/multi_channel_iot_monitor_if.sv | 35 +++
 rtl/multi_channel_iot_monitor.sv | 104 ++++++++++
 tb/tb_multi_channel_iot_monitor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_iot_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : multi_channel_iot_monitor_if                                 |
// | Brief   : Event/status bundle between the device-event front end and   |
// |           the multi-channel IoT monitor.                               |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface multi_channel_iot_monitor_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int TOT_W = 10
);
    logic [N_CH-1:0]       change;
    logic [N_CH-1:0]       on_off;
    logic [N_CH-1:0]       clear;
    logic [WIDTH-1:0]      threshold;
    logic [N_CH*WIDTH-1:0] counter_out;
    logic [TOT_W-1:0]      total_out;
    logic [N_CH-1:0]       boundary;
    logic [N_CH-1:0]       alarm;
    logic                  any_alarm;

    // Event source side: drives the per-channel requests, observes status
    modport master (
        output change, on_off, clear, threshold,
        input  counter_out, total_out, boundary, alarm, any_alarm
    );

    // Monitor side: consumes requests, produces status
    modport slave (
        input  change, on_off, clear, threshold,
        output counter_out, total_out, boundary, alarm, any_alarm
    );
endinterface
`default_nettype wire

// File: rtl/multi_channel_iot_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : multi_channel_iot_monitor                                    |
// | Brief   : N_CH independent up/down active-device counters with wrap or |
// |           saturate arithmetic, per-channel clear, boundary pulses, a   |
// |           registered grand total and per-channel threshold alarms.     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module multi_channel_iot_monitor #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int TOT_W    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    multi_channel_iot_monitor_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_max    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero   = {WIDTH{1'b0}};
    // Count value left behind when an up/down step runs into the boundary
    localparam logic [WIDTH-1:0] c_up_lim = (SATURATE != 0) ? c_max  : c_zero;
    localparam logic [WIDTH-1:0] c_dn_lim = (SATURATE != 0) ? c_zero : c_max;

    logic [WIDTH-1:0]      r_cnt [N_CH];
    logic [N_CH-1:0]       r_bnd;
    logic [N_CH-1:0]       r_alarm;
    logic [TOT_W-1:0]      r_total;
    logic [TOT_W-1:0]      w_sum;
    logic [N_CH*WIDTH-1:0] w_cnt_flat;

    // Per-channel counters: clear beats change; a blocked/wrapping step pulses boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= c_zero;
            end
            r_bnd <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clear[i]) begin
                    r_cnt[i] <= c_zero;
                    r_bnd[i] <= 1'b0;
                end else if (bus.change[i] && bus.on_off[i]) begin
                    if (r_cnt[i] == c_max) begin
                        r_cnt[i] <= c_up_lim;
                        r_bnd[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                        r_bnd[i] <= 1'b0;
                    end
                end else if (bus.change[i]) begin
                    if (r_cnt[i] == c_zero) begin
                        r_cnt[i] <= c_dn_lim;
                        r_bnd[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - WIDTH'(1);
                        r_bnd[i] <= 1'b0;
                    end
                end else begin
                    r_bnd[i] <= 1'b0;
                end
            end
        end
    end

    // Sum of the registered channel counts; TOT_W is sized so this cannot overflow
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = w_sum + TOT_W'(r_cnt[i]);
        end
    end

    // Flatten the per-channel counts onto the output bus
    always_comb begin
        w_cnt_flat = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_flat[i*WIDTH +: WIDTH] = r_cnt[i];
        end
    end

    // Total and alarms are registered from the registered counts (one cycle behind)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            r_alarm <= '0;
        end else begin
            r_total <= w_sum;
            for (int i = 0; i < N_CH; i++) begin
                r_alarm[i] <= (r_cnt[i] >= bus.threshold);
            end
        end
    end

    assign bus.counter_out = w_cnt_flat;
    assign bus.total_out   = r_total;
    assign bus.boundary    = r_bnd;
    assign bus.alarm       = r_alarm;
    assign bus.any_alarm   = |r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_iot_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_multi_channel_iot_monitor                                 |
// | Brief   : Self-checking bench driving a wrap and a saturate instance   |
// |           with identical stimulus against a behavioural model.         |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_multi_channel_iot_monitor;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int TOT_W = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] change = '0;
    logic [3:0] on_off = '0;
    logic [3:0] clear  = '0;
    logic [7:0] threshold = '0;

    int checks   = 0;
    int failures = 0;

    multi_channel_iot_monitor_if #(.N_CH(N_CH), .WIDTH(WIDTH), .TOT_W(TOT_W)) if_w ();
    multi_channel_iot_monitor_if #(.N_CH(N_CH), .WIDTH(WIDTH), .TOT_W(TOT_W)) if_s ();

    assign if_w.change    = change;
    assign if_w.on_off    = on_off;
    assign if_w.clear     = clear;
    assign if_w.threshold = threshold;
    assign if_s.change    = change;
    assign if_s.on_off    = on_off;
    assign if_s.clear     = clear;
    assign if_s.threshold = threshold;

    multi_channel_iot_monitor #(.N_CH(N_CH), .WIDTH(WIDTH), .SATURATE(0), .TOT_W(TOT_W)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (if_w.slave)
    );

    multi_channel_iot_monitor #(.N_CH(N_CH), .WIDTH(WIDTH), .SATURATE(1), .TOT_W(TOT_W)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_s.slave)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = wrap instance, 1 = saturate instance
    int m_cnt [2][4];
    bit m_bnd [2][4];
    bit m_alm [2][4];
    int m_tot [2];

    function automatic void model_update(input bit r, input logic [3:0] ch, input logic [3:0] on,
                                         input logic [3:0] cl, input logic [7:0] thr);
        int prev [2][4];
        int n;
        prev = m_cnt;
        for (int d = 0; d < 2; d++) begin
            m_tot[d] = 0;
            for (int i = 0; i < 4; i++) begin
                if (r) begin
                    m_cnt[d][i] = 0;
                    m_bnd[d][i] = 1'b0;
                    m_alm[d][i] = 1'b0;
                end else begin
                    m_tot[d]    = m_tot[d] + prev[d][i];
                    m_alm[d][i] = (prev[d][i] >= int'(thr));
                    if (cl[i]) begin
                        m_cnt[d][i] = 0;
                        m_bnd[d][i] = 1'b0;
                    end else if (ch[i]) begin
                        n = prev[d][i] + (on[i] ? 1 : -1);
                        if (n > 255 || n < 0) begin
                            m_bnd[d][i] = 1'b1;
                            if (d == 1) m_cnt[d][i] = (n < 0) ? 0 : 255;
                            else        m_cnt[d][i] = ((n % 256) + 256) % 256;
                        end else begin
                            m_cnt[d][i] = n;
                            m_bnd[d][i] = 1'b0;
                        end
                    end else begin
                        m_bnd[d][i] = 1'b0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_cnt(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(m_cnt[d][i]);
        return v;
    endfunction

    function automatic logic [3:0] exp_bnd(input int d);
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_bnd[d][i];
        return v;
    endfunction

    function automatic logic [3:0] exp_alm(input int d);
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_alm[d][i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("w_counter", if_w.counter_out, exp_cnt(0));
        check("w_total", 32'(if_w.total_out), 32'(m_tot[0]));
        check("w_boundary", 32'(if_w.boundary), 32'(exp_bnd(0)));
        check("w_alarm", 32'(if_w.alarm), 32'(exp_alm(0)));
        check("w_any_alarm", 32'(if_w.any_alarm), 32'(|exp_alm(0)));
        check("s_counter", if_s.counter_out, exp_cnt(1));
        check("s_total", 32'(if_s.total_out), 32'(m_tot[1]));
        check("s_boundary", 32'(if_s.boundary), 32'(exp_bnd(1)));
        check("s_alarm", 32'(if_s.alarm), 32'(exp_alm(1)));
        check("s_any_alarm", 32'(if_s.any_alarm), 32'(|exp_alm(1)));
    endtask

    // Apply one cycle of inputs, advance the model, sample 1ns after the edge
    task automatic step(input bit r, input logic [3:0] ch, input logic [3:0] on,
                        input logic [3:0] cl, input logic [7:0] thr);
        rst = r; change = ch; on_off = on; clear = cl; threshold = thr;
        @(posedge clk);
        model_update(r, ch, on, cl, thr);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_cnt"}, if_w.counter_out, 32'h0);
        check({tag, "_w_tot"}, 32'(if_w.total_out), 32'h0);
        check({tag, "_w_bnd"}, 32'(if_w.boundary), 32'h0);
        check({tag, "_w_alm"}, 32'({if_w.alarm, if_w.any_alarm}), 32'h0);
        check({tag, "_s_cnt"}, if_s.counter_out, 32'h0);
        check({tag, "_s_tot"}, 32'(if_s.total_out), 32'h0);
        check({tag, "_s_bnd"}, 32'(if_s.boundary), 32'h0);
        check({tag, "_s_alm"}, 32'({if_s.alarm, if_s.any_alarm}), 32'h0);
    endtask

    typedef struct {
        bit          r;
        logic [3:0]  ch;
        logic [3:0]  on;
        logic [3:0]  cl;
        logic [7:0]  thr;
        logic [31:0] cnt_w;
        logic [9:0]  tot_w;
        logic [3:0]  bnd_w;
        logic [31:0] cnt_s;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Up x5 / down x2 on ch0, then wrap vs saturate on ch1 from zero
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd100, 32'h0000_0000, 10'd0,   4'h0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 4'h1, 4'h1, 4'h0, 8'd100, 32'h0000_0001, 10'd0,   4'h0, 32'h0000_0001};
        tbl[2]  = '{1'b0, 4'h1, 4'h1, 4'h0, 8'd100, 32'h0000_0002, 10'd1,   4'h0, 32'h0000_0002};
        tbl[3]  = '{1'b0, 4'h1, 4'h1, 4'h0, 8'd100, 32'h0000_0003, 10'd2,   4'h0, 32'h0000_0003};
        tbl[4]  = '{1'b0, 4'h1, 4'h1, 4'h0, 8'd100, 32'h0000_0004, 10'd3,   4'h0, 32'h0000_0004};
        tbl[5]  = '{1'b0, 4'h1, 4'h1, 4'h0, 8'd100, 32'h0000_0005, 10'd4,   4'h0, 32'h0000_0005};
        tbl[6]  = '{1'b0, 4'h1, 4'h0, 4'h0, 8'd100, 32'h0000_0004, 10'd5,   4'h0, 32'h0000_0004};
        tbl[7]  = '{1'b0, 4'h1, 4'h0, 4'h0, 8'd100, 32'h0000_0003, 10'd4,   4'h0, 32'h0000_0003};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 8'd100, 32'h0000_0003, 10'd3,   4'h0, 32'h0000_0003};
        tbl[9]  = '{1'b1, 4'h0, 4'h0, 4'h0, 8'd100, 32'h0000_0000, 10'd0,   4'h0, 32'h0000_0000};
        tbl[10] = '{1'b0, 4'h2, 4'h0, 4'h0, 8'd100, 32'h0000_FF00, 10'd0,   4'h2, 32'h0000_0000};
        tbl[11] = '{1'b0, 4'h2, 4'h2, 4'h0, 8'd100, 32'h0000_0000, 10'd255, 4'h2, 32'h0000_0100};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 8'd100, 32'h0000_0000, 10'd0,   4'h0, 32'h0000_0100};

        // Reset held 2 cycles with random inputs, then idle: everything stays 0
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            check_all_zero("reset");
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 4'($urandom), 4'h0, 8'd50);
            check("idle_w_cnt", if_w.counter_out, 32'h0);
            check("idle_s_cnt", if_s.counter_out, 32'h0);
        end

        // Table-driven vectors
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].r, tbl[k].ch, tbl[k].on, tbl[k].cl, tbl[k].thr);
            check($sformatf("tbl%0d_w_cnt", k), if_w.counter_out, tbl[k].cnt_w);
            check($sformatf("tbl%0d_w_tot", k), 32'(if_w.total_out), 32'(tbl[k].tot_w));
            check($sformatf("tbl%0d_w_bnd", k), 32'(if_w.boundary), 32'(tbl[k].bnd_w));
            check($sformatf("tbl%0d_s_cnt", k), if_s.counter_out, tbl[k].cnt_s);
        end

        // Saturation on ch2: climb to 255, then three blocked up-steps
        step(1'b1, 4'h0, 4'h0, 4'h0, 8'd200);
        for (int k = 0; k < 255; k++) step(1'b0, 4'h4, 4'h4, 4'h0, 8'd200);
        check("sat_reach_255", 32'(if_s.counter_out[23:16]), 32'd255);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h4, 4'h4, 4'h0, 8'd200);
            check("sat_hold_255", 32'(if_s.counter_out[23:16]), 32'd255);
            check("sat_bnd_up", 32'(if_s.boundary), 32'h4);
        end
        step(1'b0, 4'h4, 4'h4, 4'h4, 8'd200);
        check("sat_clear", 32'(if_s.counter_out[23:16]), 32'd0);
        check("sat_clear_bnd", 32'(if_s.boundary), 32'h0);
        step(1'b0, 4'h4, 4'h0, 4'h0, 8'd200);
        check("sat_hold_0", 32'(if_s.counter_out[23:16]), 32'd0);
        check("sat_bnd_dn", 32'(if_s.boundary), 32'h4);
        check("wrap_dn_255", 32'(if_w.counter_out[23:16]), 32'd255);
        step(1'b0, 4'h0, 4'h0, 4'h0, 8'd200);
        check("bnd_one_cycle", 32'({if_w.boundary, if_s.boundary}), 32'h0);

        // Priority: clear beats change on ch3, then reset beats everything
        step(1'b1, 4'h0, 4'h0, 4'h0, 8'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 4'h8, 4'h8, 4'h0, 8'd0);
        check("prio_ch3_10", 32'(if_w.counter_out[31:24]), 32'd10);
        step(1'b0, 4'h8, 4'h8, 4'h8, 8'd0);
        check("prio_clear_w", 32'(if_w.counter_out[31:24]), 32'd0);
        check("prio_clear_s", 32'(if_s.counter_out[31:24]), 32'd0);
        step(1'b1, 4'hF, 4'hF, 4'h0, 8'd0);
        check_all_zero("prio_rst");

        // Alarm: threshold 4, all channels up x4 together
        for (int k = 0; k < 4; k++) step(1'b0, 4'hF, 4'hF, 4'h0, 8'd4);
        check("alm_counts", if_w.counter_out, 32'h0404_0404);
        check("alm_not_yet", 32'(if_w.alarm), 32'h0);
        step(1'b0, 4'h0, 4'h0, 4'h0, 8'd4);
        check("alm_total16", 32'(if_w.total_out), 32'd16);
        check("alm_all", 32'(if_w.alarm), 32'hF);
        check("alm_any", 32'(if_w.any_alarm), 32'h1);
        step(1'b0, 4'h1, 4'h0, 4'h0, 8'd4);
        check("alm_ch0_3", 32'(if_w.counter_out[7:0]), 32'd3);
        check("alm_still", 32'(if_w.alarm), 32'hF);
        step(1'b0, 4'h0, 4'h0, 4'h0, 8'd4);
        check("alm_drop0", 32'(if_w.alarm), 32'hE);
        check("alm_any_hold", 32'(if_w.any_alarm), 32'h1);

        // Randomized: balanced walk, then up-biased to reach the top boundary
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom),
                 4'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8)));
        end
        for (int k = 0; k < 900; k++) begin
            step(($urandom_range(0, 299) == 0), 4'($urandom | $urandom), 4'($urandom | $urandom),
                 4'($urandom & $urandom & $urandom & $urandom),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
